// File: rtl/umips_imem_port.sv
// umips_imem_port: instruction fetch port with a one-word buffer, req/ack memory handshake,
// flush-while-outstanding handling and sticky bus-error trapping.
module umips_imem_port #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        fault,
    output logic [31:0] fault_addr
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t      state_q;
    logic        mem_req_q, buf_valid_q, fault_q;
    logic [29:0] mem_addr_q, buf_addr_q;
    logic [31:0] buf_data_q, fault_addr_q;
    logic        hit, unused_pc_lsb;
    assign unused_pc_lsb = ^pc_addr[1:0];
    assign hit         = buf_valid_q && (buf_addr_q == pc_addr[31:2]);
    assign instr       = buf_data_q;
    assign instr_valid = pc_valid && !flush && !fault_q && hit;
    assign stall       = pc_valid && !flush && (fault_q || !hit);
    assign mem_req     = mem_req_q;
    assign mem_addr    = {mem_addr_q, 2'b00};
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= RESET_ADDR[31:2];
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= RESET_ADDR[31:2];
            buf_data_q   <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            if (flush) begin
                buf_valid_q <= 1'b0;
                fault_q     <= 1'b0;
            end
            case (state_q)
                IDLE: if (pc_valid && !hit && !flush && !fault_q) begin
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= pc_addr[31:2];
                    state_q    <= REQ;
                end
                REQ: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                    if (!flush) begin
                        buf_addr_q  <= mem_addr_q;
                        buf_valid_q <= !mem_err;
                        if (mem_err) begin
                            fault_q      <= 1'b1;
                            fault_addr_q <= {mem_addr_q, 2'b00};
                        end else begin
                            buf_data_q <= mem_rdata;
                        end
                    end
                end else if (flush) begin
                    state_q <= DISCARD;
                end
                // the cancelled read must still complete before a new one may be issued
                DISCARD: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
